// File: rtl/rob_multi_commit.sv
// rob_multi_commit: reorder buffer with multi-slot in-order retirement, operand forwarding and mispredict flush
module rob_multi_commit #(
  parameter int DEPTH_BIT = 5,
  parameter int COMMIT_W = 2,
  parameter int WB_PORTS = 2,
  parameter int XLEN = 32
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          disp_valid,
  input  logic                          disp_ready_now,
  input  logic [1:0]                    disp_type,
  input  logic [4:0]                    disp_rd,
  input  logic [XLEN-1:0]               disp_val,
  input  logic [XLEN-1:0]               disp_pc,
  input  logic [XLEN-1:0]               disp_pred_pc,
  output logic [DEPTH_BIT-1:0]          alloc_id,
  output logic                          rob_full,
  output logic [DEPTH_BIT:0]            rob_count,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*DEPTH_BIT-1:0] wb_id,
  input  logic [WB_PORTS*XLEN-1:0]      wb_val,
  input  logic [2*DEPTH_BIT-1:0]        q_id,
  output logic [1:0]                    q_ready,
  output logic [2*XLEN-1:0]             q_val,
  output logic [COMMIT_W-1:0]           commit_valid,
  output logic [COMMIT_W-1:0]           commit_wr,
  output logic [COMMIT_W*5-1:0]         commit_rd,
  output logic [COMMIT_W*XLEN-1:0]      commit_val,
  output logic [COMMIT_W*DEPTH_BIT-1:0] commit_id,
  output logic                          head_is_mem,
  output logic [DEPTH_BIT-1:0]          head_id,
  output logic                          flush,
  output logic [XLEN-1:0]               redirect_pc,
  output logic [31:0]                   commit_cnt
);
  localparam int DEPTH = 1 << DEPTH_BIT;
  localparam logic [1:0] T_LOAD = 2'd1, T_STORE = 2'd2, T_BR = 2'd3;
  typedef logic [DEPTH_BIT-1:0] ptr_t;
  typedef logic [DEPTH_BIT:0] cnt_t;

  logic [DEPTH-1:0] busy_q, busy_d, rdy_q, rdy_d;
  logic [1:0] type_q [DEPTH];
  logic [1:0] type_d [DEPTH];
  logic [4:0] rd_q [DEPTH];
  logic [4:0] rd_d [DEPTH];
  logic [XLEN-1:0] val_q [DEPTH];
  logic [XLEN-1:0] val_d [DEPTH];
  logic [XLEN-1:0] pred_q [DEPTH];
  logic [XLEN-1:0] pred_d [DEPTH];
  ptr_t head_q, head_d, tail_q, tail_d;
  cnt_t count_q, count_d;
  logic flush_q, flush_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic [31:0] commit_cnt_q, commit_cnt_d;
  ptr_t slot_id [COMMIT_W];
  logic [COMMIT_W-1:0] slot_ok, slot_mis;
  cnt_t n_commit;
  logic go, seen_store, do_disp;
  ptr_t qi [2];
  logic [1:0] q_hit, d_hit;
  logic [XLEN-1:0] q_wv [2];
  logic unused_pc;

  assign unused_pc = ^disp_pc;
  assign alloc_id = tail_q;
  assign rob_count = count_q;
  assign rob_full = count_q == cnt_t'(DEPTH);
  assign head_id = head_q;
  assign head_is_mem = busy_q[head_q] && (type_q[head_q] == T_LOAD || type_q[head_q] == T_STORE);
  assign flush = flush_q;
  assign redirect_pc = redirect_q;
  assign commit_cnt = commit_cnt_q;

  // A group grows from head while entries are ready; a mispredict or a second store closes it.
  always_comb begin
    go = rdy_in && !flush_q;
    seen_store = 1'b0;
    n_commit = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      slot_id[k] = head_q + ptr_t'(k);
      slot_mis[k] = type_q[slot_id[k]] == T_BR && val_q[slot_id[k]] != pred_q[slot_id[k]];
      go = go && busy_q[slot_id[k]] && rdy_q[slot_id[k]] && !(seen_store && type_q[slot_id[k]] == T_STORE);
      slot_ok[k] = go;
      seen_store = seen_store || type_q[slot_id[k]] == T_STORE;
      go = go && !slot_mis[k];
      n_commit = n_commit + cnt_t'(slot_ok[k]);
      commit_valid[k] = slot_ok[k];
      commit_wr[k] = slot_ok[k] && type_q[slot_id[k]] < T_STORE && rd_q[slot_id[k]] != 5'd0;
      commit_rd[k*5 +: 5] = slot_ok[k] ? rd_q[slot_id[k]] : 5'd0;
      commit_val[k*XLEN +: XLEN] = slot_ok[k] ? val_q[slot_id[k]] : '0;
      commit_id[k*DEPTH_BIT +: DEPTH_BIT] = slot_ok[k] ? slot_id[k] : '0;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      qi[i] = q_id[i*DEPTH_BIT +: DEPTH_BIT];
      q_hit[i] = 1'b0;
      q_wv[i] = '0;
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_valid[p] && wb_id[p*DEPTH_BIT +: DEPTH_BIT] == qi[i]) begin
          q_hit[i] = 1'b1;
          q_wv[i] = wb_val[p*XLEN +: XLEN];
        end
      d_hit[i] = disp_valid && disp_ready_now && tail_q == qi[i];
      q_ready[i] = rdy_q[qi[i]] || q_hit[i] || d_hit[i];
      q_val[i*XLEN +: XLEN] = rdy_q[qi[i]] ? val_q[qi[i]] : q_hit[i] ? q_wv[i] : d_hit[i] ? disp_val : '0;
    end
  end

  always_comb begin
    busy_d = busy_q;
    rdy_d = rdy_q;
    type_d = type_q;
    rd_d = rd_q;
    val_d = val_q;
    pred_d = pred_q;
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    flush_d = 1'b0;
    redirect_d = redirect_q;
    commit_cnt_d = commit_cnt_q;
    do_disp = 1'b0;
    if (flush_q) begin
      busy_d = '0;
      rdy_d = '0;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end else begin
      flush_d = |(slot_ok & slot_mis);
      for (int k = 0; k < COMMIT_W; k++)
        if (slot_ok[k] && slot_mis[k]) redirect_d = val_q[slot_id[k]];
      if (!flush_d) begin
        for (int p = 0; p < WB_PORTS; p++)
          if (wb_valid[p] && busy_q[wb_id[p*DEPTH_BIT +: DEPTH_BIT]]) begin
            rdy_d[wb_id[p*DEPTH_BIT +: DEPTH_BIT]] = 1'b1;
            val_d[wb_id[p*DEPTH_BIT +: DEPTH_BIT]] = wb_val[p*XLEN +: XLEN];
          end
        do_disp = disp_valid && !rob_full;
        if (do_disp) begin
          busy_d[tail_q] = 1'b1;
          rdy_d[tail_q] = disp_ready_now;
          type_d[tail_q] = disp_type;
          rd_d[tail_q] = disp_rd;
          val_d[tail_q] = disp_val;
          pred_d[tail_q] = disp_pred_pc;
          tail_d = tail_q + ptr_t'(1);
        end
      end
      for (int k = 0; k < COMMIT_W; k++)
        if (slot_ok[k]) begin
          busy_d[slot_id[k]] = 1'b0;
          rdy_d[slot_id[k]] = 1'b0;
        end
      head_d = head_q + ptr_t'(n_commit);
      count_d = count_q - n_commit + cnt_t'(do_disp);
      commit_cnt_d = commit_cnt_q + 32'(n_commit);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      busy_q <= '0;
      rdy_q <= '0;
      type_q <= '{default: '0};
      rd_q <= '{default: '0};
      val_q <= '{default: '0};
      pred_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
      redirect_q <= '0;
      commit_cnt_q <= '0;
    end else if (rdy_in) begin
      busy_q <= busy_d;
      rdy_q <= rdy_d;
      type_q <= type_d;
      rd_q <= rd_d;
      val_q <= val_d;
      pred_q <= pred_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      flush_q <= flush_d;
      redirect_q <= redirect_d;
      commit_cnt_q <= commit_cnt_d;
    end
endmodule

// File: tb/tb_rob_multi_commit.sv
// tb_rob_multi_commit: directed scenarios plus random traffic checked against a queue-based reorder buffer model
module tb_rob_multi_commit;
  localparam int DB = 5, CW = 2, WP = 2, XL = 32, DEPTH = 32;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, disp_valid, disp_ready_now;
  logic [1:0] disp_type;
  logic [4:0] disp_rd;
  logic [XL-1:0] disp_val, disp_pc, disp_pred_pc;
  logic [DB-1:0] alloc_id, head_id;
  logic rob_full, head_is_mem, flush;
  logic [DB:0] rob_count;
  logic [WP-1:0] wb_valid;
  logic [WP*DB-1:0] wb_id;
  logic [WP*XL-1:0] wb_val;
  logic [2*DB-1:0] q_id;
  logic [1:0] q_ready;
  logic [2*XL-1:0] q_val;
  logic [CW-1:0] commit_valid, commit_wr;
  logic [CW*5-1:0] commit_rd;
  logic [CW*XL-1:0] commit_val;
  logic [CW*DB-1:0] commit_id;
  logic [XL-1:0] redirect_pc;
  logic [31:0] commit_cnt;

  always #5 clk_in = ~clk_in;

  rob_multi_commit #(.DEPTH_BIT(DB), .COMMIT_W(CW), .WB_PORTS(WP), .XLEN(XL)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .disp_valid(disp_valid),
    .disp_ready_now(disp_ready_now), .disp_type(disp_type), .disp_rd(disp_rd), .disp_val(disp_val),
    .disp_pc(disp_pc), .disp_pred_pc(disp_pred_pc), .alloc_id(alloc_id), .rob_full(rob_full),
    .rob_count(rob_count), .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val), .q_id(q_id),
    .q_ready(q_ready), .q_val(q_val), .commit_valid(commit_valid), .commit_wr(commit_wr),
    .commit_rd(commit_rd), .commit_val(commit_val), .commit_id(commit_id), .head_is_mem(head_is_mem),
    .head_id(head_id), .flush(flush), .redirect_pc(redirect_pc), .commit_cnt(commit_cnt)
  );

  int checks = 0, errors = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { bit rdy; bit [1:0] ty; bit [4:0] rd; bit [31:0] val; bit [31:0] pred; } ent_t;
  ent_t mq[$];
  int m_head, exp_n;
  bit m_flush, exp_mis;
  bit [31:0] m_redir, m_cnt;

  function automatic int slot_of(int tag);
    return (tag - m_head + DEPTH) % DEPTH;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_head = 0;
    m_flush = 0;
    m_redir = 0;
    m_cnt = 0;
  endtask

  task automatic plan();
    bit st;
    st = 0;
    exp_n = 0;
    exp_mis = 0;
    if (!rdy_in || m_flush) return;
    while (exp_n < CW && exp_n < mq.size()) begin
      if (!mq[exp_n].rdy || (st && mq[exp_n].ty == 2)) break;
      st |= mq[exp_n].ty == 2;
      exp_mis = mq[exp_n].ty == 3 && mq[exp_n].val != mq[exp_n].pred;
      exp_n++;
      if (exp_mis) break;
    end
  endtask

  task automatic check_all();
    logic [CW-1:0] ev, ew;
    logic [CW*5-1:0] erd, mrd;
    logic [CW*XL-1:0] evl, mvl;
    logic [CW*DB-1:0] eid, mid;
    logic [1:0] eqr;
    logic [2*XL-1:0] eqv, mqv;
    bit mem;
    plan();
    {ev, ew, erd, mrd, evl, mvl, eid, mid, eqr, eqv, mqv} = '0;
    for (int k = 0; k < exp_n; k++) begin
      ev[k] = 1'b1;
      ew[k] = mq[k].ty < 2 && mq[k].rd != 0;
      erd[k*5 +: 5] = mq[k].rd;
      mrd[k*5 +: 5] = '1;
      evl[k*XL +: XL] = mq[k].val;
      mvl[k*XL +: XL] = '1;
      eid[k*DB +: DB] = DB'((m_head + k) % DEPTH);
      mid[k*DB +: DB] = '1;
    end
    for (int i = 0; i < 2; i++) begin
      int t, s;
      bit hit;
      logic [31:0] v;
      t = int'(q_id[i*DB +: DB]);
      s = slot_of(t);
      hit = 0;
      v = '0;
      if (s < mq.size() && mq[s].rdy) begin hit = 1; v = mq[s].val; end
      for (int p = WP - 1; p >= 0; p--)
        if (!hit && wb_valid[p] && int'(wb_id[p*DB +: DB]) == t) begin hit = 1; v = wb_val[p*XL +: XL]; end
      if (!hit && disp_valid && disp_ready_now && (m_head + mq.size()) % DEPTH == t) begin hit = 1; v = disp_val; end
      eqr[i] = hit;
      eqv[i*XL +: XL] = v;
      if (hit) mqv[i*XL +: XL] = '1;
    end
    mem = 0;
    if (mq.size() > 0) mem = mq[0].ty == 1 || mq[0].ty == 2;
    chk("count", rob_count, mq.size());
    chk("full", rob_full, mq.size() == DEPTH);
    chk("alloc", alloc_id, (m_head + mq.size()) % DEPTH);
    chk("head", head_id, m_head);
    chk("head_mem", head_is_mem, mem);
    chk("flush", flush, m_flush);
    if (m_flush) chk("redirect", redirect_pc, m_redir);
    chk("ccnt", commit_cnt, m_cnt);
    chk("cvalid", commit_valid, ev);
    chk("cwr", commit_wr, ew);
    chk("crd", commit_rd & mrd, erd);
    chk("cval", commit_val & mvl, evl);
    chk("cid", commit_id & mid, eid);
    chk("qrdy", q_ready, eqr);
    chk("qval", q_val & mqv, eqv);
  endtask

  task automatic advance();
    if (!rdy_in) return;
    if (m_flush) begin
      mq.delete();
      m_head = 0;
      m_flush = 0;
      return;
    end
    if (exp_mis) begin
      m_flush = 1;
      m_redir = mq[exp_n-1].val;
    end else begin
      for (int p = 0; p < WP; p++)
        if (wb_valid[p]) begin
          int s;
          s = slot_of(int'(wb_id[p*DB +: DB]));
          if (s < mq.size()) begin mq[s].rdy = 1; mq[s].val = wb_val[p*XL +: XL]; end
        end
      if (disp_valid && mq.size() < DEPTH)
        mq.push_back('{rdy: disp_ready_now, ty: disp_type, rd: disp_rd, val: disp_val, pred: disp_pred_pc});
    end
    for (int k = 0; k < exp_n; k++) void'(mq.pop_front());
    m_head = (m_head + exp_n) % DEPTH;
    m_cnt += 32'(exp_n);
  endtask

  task automatic step();
    #1;
    check_all();
    advance();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1;
    disp_valid = 0;
    disp_ready_now = 0;
    disp_type = 0;
    disp_rd = 0;
    disp_val = 0;
    disp_pc = 0;
    disp_pred_pc = 0;
    wb_valid = 0;
    wb_id = 0;
    wb_val = 0;
  endtask

  task automatic dsp(int ty, int rn, int rd, logic [31:0] v, logic [31:0] pr);
    disp_valid = 1;
    disp_type = 2'(ty);
    disp_ready_now = rn != 0;
    disp_rd = 5'(rd);
    disp_val = v;
    disp_pred_pc = pr;
    disp_pc = $urandom;
  endtask

  task automatic wbp(int p, int tag, logic [31:0] v);
    wb_valid[p] = 1;
    wb_id[p*DB +: DB] = DB'(tag);
    wb_val[p*XL +: XL] = v;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1;
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 0;
  endtask

  initial begin
    int seq;
    q_id = 0;
    idle();
    rst_in = 1;
    model_reset();
    #2;
    chk("rst_count", rob_count, 0);
    chk("rst_full", rob_full, 0);
    chk("rst_cvalid", commit_valid, 0);
    chk("rst_qrdy", q_ready, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redir", redirect_pc, 0);
    chk("rst_ccnt", commit_cnt, 0);
    chk("rst_alloc", alloc_id, 0);
    do_reset();

    for (int i = 1; i <= 3; i++) begin idle(); dsp(0, 0, i, 0, 0); step(); end
    idle(); wbp(0, 2, 32'h22); step();
    idle(); #1; chk("t1_wait", commit_valid, 2'b00);
    wbp(0, 0, 32'h10); wbp(1, 1, 32'h11); step();
    idle(); #1; chk("t1_pair", commit_valid, 2'b11); chk("t1_pair_id", commit_id, {5'd1, 5'd0}); step();
    idle(); #1; chk("t1_last", commit_valid, 2'b01); chk("t1_last_id", commit_id[DB-1:0], 2); step();
    chk("t1_ccnt", commit_cnt, 3);

    do_reset();
    for (int i = 0; i < DEPTH; i++) begin idle(); dsp(0, 0, i, 0, 0); step(); end
    idle(); #1; chk("full_flag", rob_full, 1); chk("full_count", rob_count, 32);
    wbp(0, 0, 32'h5); wbp(1, 1, 32'h6); step();
    idle(); dsp(0, 1, 7, 32'h77, 0); #1; chk("full_commit", commit_valid, 2'b11); chk("full_held", rob_full, 1); step();
    idle(); #1; chk("full_after", rob_count, 30); chk("full_clear", rob_full, 0);
    dsp(0, 1, 8, 32'h88, 0); step();
    idle(); #1; chk("full_refill", rob_count, 31);

    do_reset();
    idle(); dsp(3, 0, 0, 0, 32'h100); step();
    idle(); dsp(0, 1, 4, 32'h44, 0); step();
    idle(); wbp(0, 0, 32'h200); step();
    idle(); #1; chk("mis_only_br", commit_valid, 2'b01); step();
    idle(); #1; chk("mis_flush", flush, 1); chk("mis_redir", redirect_pc, 32'h200); step();
    idle(); #1; chk("mis_unflush", flush, 0); chk("mis_count", rob_count, 0);
    chk("mis_head", head_id, 0); chk("mis_tail", alloc_id, 0); step();

    do_reset();
    for (int i = 0; i < 6; i++) begin idle(); dsp(0, 0, 1, 0, 0); step(); end
    idle(); q_id = {5'd0, 5'd5}; wbp(0, 5, 32'hAAAA); wbp(1, 5, 32'hBBBB);
    #1; chk("fwd_rdy", q_ready[0], 1); chk("fwd_val", q_val[XL-1:0], 32'hBBBB); step();
    idle(); #1; chk("fwd_stored_rdy", q_ready[0], 1); chk("fwd_stored", q_val[XL-1:0], 32'hBBBB); step();

    do_reset();
    seq = 0;
    for (int i = 0; i < 71; i++) begin
      idle();
      if (i < 70) dsp(0, 1, i % 32, 32'(i), 0);
      #1;
      if (commit_valid[0]) begin chk("wrap_id", commit_id[DB-1:0], seq % 32); seq++; end
      chk("wrap_nofull", rob_full, 0);
      step();
    end
    chk("wrap_total", seq, 70);

    do_reset();
    for (int i = 0; i < 3; i++) begin idle(); dsp(1, 0, 5, 0, 0); step(); end
    idle(); wbp(0, 0, 32'h1); wbp(1, 1, 32'h2); step();
    for (int i = 0; i < 3; i++) begin
      idle(); rdy_in = 0; #1;
      chk("stall_cv", commit_valid, 0);
      chk("stall_head", head_id, 0);
      step();
    end
    idle(); rdy_in = 0; #2; rst_in = 1; #1;
    chk("arst_count", rob_count, 0);
    chk("arst_head", head_id, 0);
    chk("arst_alloc", alloc_id, 0);
    chk("arst_cv", commit_valid, 0);
    chk("arst_qrdy", q_ready, 0);
    chk("arst_mem", head_is_mem, 0);
    model_reset();
    @(posedge clk_in); #1; rst_in = 0;

    for (int c = 0; c < 3000; c++) begin
      idle();
      rdy_in = $urandom_range(9) != 0;
      if ($urandom_range(1) == 1) begin
        int ty;
        logic [31:0] pr;
        ty = $urandom_range(3);
        pr = 32'($urandom_range(15)) << 2;
        dsp(ty, $urandom_range(3) == 0, $urandom_range(31),
            ty == 3 ? ($urandom_range(9) < 7 ? pr : pr + 4) : $urandom, pr);
      end
      for (int p = 0; p < WP; p++)
        if ($urandom_range(1) == 1) begin
          if (mq.size() > 0 && $urandom_range(3) != 0) begin
            int s;
            s = $urandom_range(mq.size() - 1);
            wbp(p, (m_head + s) % DEPTH,
                mq[s].ty == 3 ? ($urandom_range(9) < 7 ? mq[s].pred : mq[s].pred + 8) : $urandom);
          end else wbp(p, $urandom_range(31), $urandom);
        end
      q_id = 10'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
